// File: rtl/swap_monitor_pkg.sv
// Shared definitions for the swap register monitor: FSM encoding and
// the default counter width.
package swap_monitor_pkg;

    localparam int DEF_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

endpackage

// File: rtl/swap_monitor_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up on inc until the counter reaches its maximum value.
    always_ff @(posedge ck) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/swap_monitor.sv
// Checker for a two-flip-flop swap register. While load is low it verifies
// on every edge that q1/q2 are the exchanged values of the previous sample,
// counting good swaps and errors and flagging q1 == q2 (degenerate swap).
module swap_monitor
    import swap_monitor_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         ck,
    input  logic         reset,
    input  logic         load,
    input  logic         q1,
    input  logic         q2,
    output logic [W-1:0] swaps,
    output logic [W-1:0] errors,
    output logic         err,
    output logic         degen,
    output logic         active
);

    state_t state;
    state_t state_next;
    logic   p1;
    logic   p2;
    logic   compare;
    logic   match;

    // The first load-low edge only captures a reference sample; comparisons
    // start on the following edge and stop as soon as load rises again.
    always_comb begin
        state_next = state;
        compare    = 1'b0;
        case (state)
            IDLE: begin
                if (!load) state_next = CHECK;
            end
            CHECK: begin
                if (load) state_next = IDLE;
                else      compare    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign match  = (q1 == p2) && (q2 == p1);
    assign active = (state == CHECK);

    // State register.
    always_ff @(posedge ck) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Previous-cycle samples of q1/q2; refreshed every edge regardless of state.
    always_ff @(posedge ck) begin
        if (reset) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p1 <= q1;
            p2 <= q2;
        end
    end

    // Sticky flags; err stays set even after the errors counter saturates.
    always_ff @(posedge ck) begin
        if (reset) begin
            err   <= 1'b0;
            degen <= 1'b0;
        end else if (compare) begin
            if (!match)   err   <= 1'b1;
            if (q1 == q2) degen <= 1'b1;
        end
    end

    sat_counter #(.W(W)) u_swaps (
        .ck    (ck),
        .reset (reset),
        .inc   (compare && match),
        .q     (swaps)
    );

    sat_counter #(.W(W)) u_errors (
        .ck    (ck),
        .reset (reset),
        .inc   (compare && !match),
        .q     (errors)
    );

endmodule
